// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and output saturation for the conv engine.
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BFETCH,
    S_BIAS,
    S_TAP,
    S_WAIT,
    S_WRITE,
    S_POOL,
    S_FIN
  } state_t;

  function automatic logic [7:0] clamp8(input logic signed [31:0] x);
    if (x < 0)
      return 8'd0;
    else if (x > 255)
      return 8'd255;
    else
      return x[7:0];
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// 3x3 multiply-accumulate: pads out-of-image taps, accumulates nine products,
// then shifts and clamps the final sum into an 8-bit result.
module conv_mac9 #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_p0,
  input  logic              pad_p0,
  input  logic              first_p0,
  input  logic              last_p0,
  input  logic [DATA_W-1:0] img_data,
  input  logic [COEF_W-1:0] w_data,
  output logic [7:0]        value
);
  import cnn_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic                     vld_p1, pad_p1, first_p1, last_p1;
  logic signed [PROD_W-1:0] px_p1, w_p1, prod_p1;
  logic signed [ACC_W-1:0]  sum_p1, acc_p2;
  logic signed [31:0]       sum32_p1;

  // p0 -> p1: tap flags realigned with the read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      pad_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      pad_p1   <= pad_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
    end
  end

  always_comb begin
    px_p1    = {{(PROD_W-DATA_W){1'b0}}, img_data};
    w_p1     = {{(PROD_W-COEF_W){w_data[COEF_W-1]}}, w_data};
    prod_p1  = pad_p1 ? '0 : px_p1 * w_p1;
    sum_p1   = (first_p1 ? '0 : acc_p2) + {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
    sum32_p1 = {{(32-ACC_W){sum_p1[ACC_W-1]}}, sum_p1};
  end

  // p1 -> p2: running sum and saturated result
  always_ff @(posedge clk) begin
    if (vld_p1)
      acc_p2 <= sum_p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      value <= '0;
    else if (vld_p1 && last_p1)
      value <= clamp8(sum32_p1 >>> SHIFT);
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Layer sequencer: per output channel a bias pass, then one 3x3 convolution pass per
// input channel, streamed to the result file; ends with a pooling handshake.
module conv3x3_engine #(
  parameter int IMG_W   = cnn_pkg::IMG_W,
  parameter int IMG_H   = cnn_pkg::IMG_H,
  parameter int N_IN_C  = 1,
  parameter int N_OUT_C = 8,
  parameter int SHIFT   = 7,
  parameter int ACC_W   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] img_addr,
  input  logic [7:0]  img_data,
  output logic [9:0]  w_addr,
  input  logic [7:0]  w_data,
  output logic [3:0]  b_addr,
  input  logic [7:0]  b_data,
  output logic        store,
  output logic [3:0]  out_c,
  output logic [9:0]  addr,
  output logic [7:0]  bias,
  output logic [7:0]  value,
  output logic        first_write,
  output logic        pool,
  input  logic        pool_done,
  output logic        cout_done
);
  import cnn_pkg::*;

  localparam int         HW       = IMG_W * IMG_H;
  localparam logic [9:0] POS_LAST = 10'(HW - 1);
  localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);
  localparam logic [3:0] OC_LAST  = 4'(N_OUT_C - 1);
  localparam logic [2:0] IC_LAST  = 3'(N_IN_C - 1);

  state_t      state, state_d;
  logic [3:0]  oc, oc_d, tap, tap_d;
  logic [2:0]  ic, ic_d;
  logic [5:0]  row, row_d, col, col_d, row_nx, col_nx;
  logic [9:0]  pos, pos_d, pos_nx;
  logic [1:0]  kx, kx_d, ky, ky_d;
  logic        vld_p0, pad_p0, first_p0, last_p0;
  logic        pad;
  int          iy, ix, img_lin, w_lin;

  assign b_addr = oc;

  always_comb begin
    pos_nx = pos + 10'd1;
    if (col == COL_LAST) begin
      col_nx = '0;
      row_nx = row + 6'd1;
    end else begin
      col_nx = col + 6'd1;
      row_nx = row;
    end
  end

  always_comb begin
    state_d = state;
    oc_d    = oc;
    ic_d    = ic;
    row_d   = row;
    col_d   = col;
    pos_d   = pos;
    tap_d   = tap;
    kx_d    = kx;
    ky_d    = ky;
    case (state)
      S_IDLE: begin
        if (start && !busy) begin
          state_d = S_BFETCH;
          oc_d    = '0;
          ic_d    = '0;
        end
      end
      S_BFETCH: begin
        state_d = S_BIAS;
        pos_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
      S_BIAS: begin
        if (pos == POS_LAST) begin
          state_d = S_TAP;
          pos_d   = '0;
          row_d   = '0;
          col_d   = '0;
          ic_d    = '0;
          tap_d   = '0;
          kx_d    = '0;
          ky_d    = '0;
        end else begin
          pos_d = pos_nx;
          row_d = row_nx;
          col_d = col_nx;
        end
      end
      S_TAP: begin
        if (tap == 4'd8) begin
          state_d = S_WAIT;
        end else begin
          tap_d = tap + 4'd1;
          if (kx == 2'd2) begin
            kx_d = '0;
            ky_d = ky + 2'd1;
          end else begin
            kx_d = kx + 2'd1;
          end
        end
      end
      S_WAIT: state_d = S_WRITE;
      S_WRITE: begin
        tap_d = '0;
        kx_d  = '0;
        ky_d  = '0;
        if (pos != POS_LAST) begin
          state_d = S_TAP;
          pos_d   = pos_nx;
          row_d   = row_nx;
          col_d   = col_nx;
        end else begin
          pos_d = '0;
          row_d = '0;
          col_d = '0;
          if (ic != IC_LAST) begin
            ic_d    = ic + 3'd1;
            state_d = S_TAP;
          end else if (oc != OC_LAST) begin
            oc_d    = oc + 4'd1;
            ic_d    = '0;
            state_d = S_BFETCH;
          end else begin
            state_d = S_POOL;
          end
        end
      end
      S_POOL: begin
        if (pool && pool_done)
          state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        oc_d    = '0;
        ic_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap position relative to the output pixel; taps outside the image read address 0
  always_comb begin
    iy      = int'(row) + int'(ky) - 1;
    ix      = int'(col) + int'(kx) - 1;
    pad     = (iy < 0) || (iy >= IMG_H) || (ix < 0) || (ix >= IMG_W);
    img_lin = pad ? 0 : int'(ic) * HW + iy * IMG_W + ix;
    w_lin   = (int'(oc) * N_IN_C + int'(ic)) * 9 + int'(tap);
  end

  // state -> p0: result-file strobes and memory addresses, one cycle behind the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      oc          <= '0;
      ic          <= '0;
      row         <= '0;
      col         <= '0;
      pos         <= '0;
      tap         <= '0;
      kx          <= '0;
      ky          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cout_done   <= 1'b0;
      pool        <= 1'b0;
      store       <= 1'b0;
      first_write <= 1'b0;
      out_c       <= '0;
      addr        <= '0;
      bias        <= '0;
      img_addr    <= '0;
      w_addr      <= '0;
      vld_p0      <= 1'b0;
      pad_p0      <= 1'b0;
      first_p0    <= 1'b0;
      last_p0     <= 1'b0;
    end else begin
      state       <= state_d;
      oc          <= oc_d;
      ic          <= ic_d;
      row         <= row_d;
      col         <= col_d;
      pos         <= pos_d;
      tap         <= tap_d;
      kx          <= kx_d;
      ky          <= ky_d;
      busy        <= (state_d != S_IDLE) || (state == S_FIN);
      done        <= (state == S_FIN);
      cout_done   <= (state == S_FIN);
      pool        <= (state == S_POOL) && !(pool && pool_done);
      store       <= (state == S_BIAS) || (state == S_WRITE);
      first_write <= (state == S_BIAS);
      if (state == S_BIAS || state == S_WRITE) begin
        out_c <= oc;
        addr  <= pos;
      end
      if (state == S_BIAS)
        bias <= b_data;
      if (state == S_TAP) begin
        img_addr <= 12'(img_lin);
        w_addr   <= 10'(w_lin);
      end
      vld_p0   <= (state == S_TAP);
      pad_p0   <= pad;
      first_p0 <= (tap == 4'd0);
      last_p0  <= (tap == 4'd8);
    end
  end

  conv_mac9 #(
    .DATA_W (8),
    .COEF_W (8),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .vld_p0   (vld_p0),
    .pad_p0   (pad_p0),
    .first_p0 (first_p0),
    .last_p0  (last_p0),
    .img_data (img_data),
    .w_data   (w_data),
    .value    (value)
  );

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a reduced feature map, using a plain-arithmetic layer model.
module tb_conv3x3_engine;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam int SH = 7;
  localparam int HW = W * H;

  typedef struct {
    int oc;
    int addr;
    int fw;
    int bias;
    int value;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, store, first_write, pool, cout_done;
  logic        pool_done = 1'b0;
  logic [11:0] img_addr;
  logic [9:0]  w_addr, addr;
  logic [3:0]  b_addr, out_c;
  logic [7:0]  img_data = '0, w_data = '0, b_data = '0;
  logic [7:0]  bias, value;

  logic [7:0] img_mem [NI*HW];
  logic [7:0] w_mem   [NO*NI*9];
  logic [7:0] b_mem   [NO];

  wr_t exp_q[$];
  int  n_checks = 0, n_fail = 0;
  int  pool_delay = 1, pool_cnt = 0, pool_hi = 0;
  int  done_cnt = 0, cdone_cnt = 0, store_cnt = 0;
  bit  mon_en = 1'b0, pool_force = 1'b0;

  conv3x3_engine #(
    .IMG_W(W), .IMG_H(H), .N_IN_C(NI), .N_OUT_C(NO), .SHIFT(SH), .ACC_W(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_data(img_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .store(store), .out_c(out_c), .addr(addr),
    .bias(bias), .value(value), .first_write(first_write), .pool(pool),
    .pool_done(pool_done), .cout_done(cout_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_data <= (int'(img_addr) < NI*HW) ? img_mem[img_addr] : 8'd0;
    w_data   <= (int'(w_addr) < NO*NI*9) ? w_mem[w_addr] : 8'd0;
    b_data   <= (int'(b_addr) < NO) ? b_mem[b_addr] : 8'd0;
  end

  always @(negedge clk) begin
    if (pool) begin
      pool_cnt  = pool_cnt + 1;
      pool_done = pool_force || (pool_cnt >= pool_delay);
    end else begin
      pool_cnt  = 0;
      pool_done = pool_force;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pool) begin
        pool_hi++;
        check_eq("store_during_pool", store, 0);
      end
      if (done) begin
        done_cnt++;
        check_eq("cout_done_with_done", cout_done, done);
      end
      if (cout_done)
        cdone_cnt++;
      if (store) begin
        store_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_store", store, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("out_c", out_c, e.oc);
          check_eq("addr", addr, e.addr);
          check_eq("first_write", first_write, e.fw);
          if (e.fw != 0)
            check_eq("bias", bias, e.bias);
          else
            check_eq("value", value, e.value);
        end
      end
    end
  end

  // Reference: each pass computed directly from the zero-padded 3x3 convolution definition
  task automatic build_expected();
    exp_q.delete();
    for (int oc = 0; oc < NO; oc++) begin
      for (int p = 0; p < HW; p++)
        exp_q.push_back('{oc: oc, addr: p, fw: 1, bias: int'(b_mem[oc]), value: 0});
      for (int ic = 0; ic < NI; ic++) begin
        for (int r = 0; r < H; r++) begin
          for (int c = 0; c < W; c++) begin
            int acc, v;
            acc = 0;
            for (int ky = 0; ky < 3; ky++) begin
              for (int kx = 0; kx < 3; kx++) begin
                int y, x;
                y = r + ky - 1;
                x = c + kx - 1;
                if (y >= 0 && y < H && x >= 0 && x < W)
                  acc += int'(img_mem[ic*HW + y*W + x]) *
                         int'($signed(w_mem[(oc*NI + ic)*9 + ky*3 + kx]));
              end
            end
            v = acc >>> SH;
            v = (v < 0) ? 0 : ((v > 255) ? 255 : v);
            exp_q.push_back('{oc: oc, addr: r*W + c, fw: 0, bias: 0, value: v});
          end
        end
      end
    end
  endtask

  task automatic fill(input logic [7:0] pv, input logic [7:0] wv);
    foreach (img_mem[i]) img_mem[i] = pv;
    foreach (w_mem[i])   w_mem[i]   = wv;
    foreach (b_mem[i])   b_mem[i]   = 8'(i + 1);
  endtask

  task automatic fill_random();
    foreach (img_mem[i]) img_mem[i] = 8'($urandom_range(0, 255));
    foreach (w_mem[i])   w_mem[i]   = 8'($urandom_range(0, 255));
    foreach (b_mem[i])   b_mem[i]   = 8'($urandom_range(0, 255));
  endtask

  task automatic run_layer(input int pdly);
    int n_exp, lim, cyc;
    build_expected();
    n_exp      = exp_q.size();
    pool_delay = pdly;
    pool_hi    = 0;
    done_cnt   = 0;
    cdone_cnt  = 0;
    store_cnt  = 0;
    lim        = NO * (1 + HW * (1 + 11 * NI)) + pdly + 50;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    repeat (20) @(negedge clk);
    start      = 1'b1;
    pool_force = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    pool_force = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < lim) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("done_pulses", done_cnt, 1);
    check_eq("cout_done_pulses", cdone_cnt, 1);
    check_eq("pool_high_cycles", pool_hi, pdly);
    check_eq("store_count", store_cnt, n_exp);
    check_eq("missing_stores", exp_q.size(), 0);
    check_eq("busy_after_done", busy, 0);
  endtask

  initial begin
    int cyc;
    fill(8'd0, 8'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs",
             {busy, done, store, first_write, pool, cout_done, img_addr, w_addr,
              b_addr, out_c, addr, bias, value}, 0);
    rst    = 1'b1;
    mon_en = 1'b1;

    fill(8'd0, 8'd0);
    run_layer(1);

    fill(8'd2, 8'd0);
    foreach (w_mem[i]) if (i % 9 == 4) w_mem[i] = 8'd64;
    run_layer(3);

    fill(8'd1, 8'd64);
    run_layer(2);

    fill(8'd255, 8'd127);
    run_layer(1);

    fill(8'd255, 8'hFF);
    run_layer(1);

    fill(8'd0, 8'd127);
    img_mem[0] = 8'd100;
    run_layer(4);

    fill_random();
    run_layer(50);

    // Abort mid-layer while the last output channel is in a convolution pass
    fill_random();
    build_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(store && out_c == 4'(NO - 1) && !first_write) && cyc < 5000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("reached_abort_point", store && !first_write, 1);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_eq("abort_outputs",
             {busy, done, store, first_write, pool, cout_done, img_addr, w_addr,
              b_addr, out_c, addr, bias, value}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_eq("idle_after_abort", busy, 0);
    run_layer(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
